// File: rtl/labmininios_hbridge_pkg.sv
// Shared definitions for the H-bridge PWM block: command encodings, channel
// FSM states, register word offsets and the command-to-pin mapping helper.
package labmininios_hbridge_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_COAST = 2'b00;
    localparam cmd_t CMD_FWD   = 2'b01;
    localparam cmd_t CMD_REV   = 2'b10;
    localparam cmd_t CMD_BRAKE = 2'b11;

    typedef enum logic [1:0] {
        ST_COAST = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DEAD  = 2'd2
    } chan_state_e;

    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_PERIOD = 1;
    localparam int unsigned REG_STATUS = 2;
    localparam int unsigned REG_DUTY0  = 3;
    localparam int unsigned REG_CMD0   = 4;

    // {in1, in2} for a channel actively driving in the given mode.
    function automatic logic [1:0] drive_pair(input cmd_t mode, input logic pwm);
        logic [1:0] pins;
        pins = 2'b00;
        case (mode)
            CMD_FWD:   pins = {pwm, 1'b0};
            CMD_REV:   pins = {1'b0, pwm};
            CMD_BRAKE: pins = 2'b11;
            default:   pins = 2'b00;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/labmininios_hbridge_pwm_if.sv
// Avalon-MM slave bus bundle for the H-bridge PWM block.
//   address    word address (ADDR_W)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   readdata   32-bit read data, zero wait states
interface labmininios_hbridge_pwm_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/labmininios_hbridge_chan.sv
// One H-bridge channel: shadowed DUTY/CMD, PWM comparator, drive/dead-time FSM
// and registered IN1/IN2 outputs.
//   en_i          global enable (0 forces COAST)
//   upd_i         shadow -> active transfer strobe (period wrap or disabled)
//   fault_i       synchronised fault: COAST and clear commands
//   cmd_lock_i    ignore CMD writes while a fault is latched
//   cnt_i         shared PWM counter
//   duty_we_i/duty_wdata_i, cmd_we_i/cmd_wdata_i   register writes
//   duty_pend_o/cmd_pend_o   pending values for readback
//   in1_o/in2_o   bridge inputs
module labmininios_hbridge_chan
    import labmininios_hbridge_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DEAD_CYC = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             upd_i,
    input  logic             fault_i,
    input  logic             cmd_lock_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             duty_we_i,
    input  logic [CNT_W-1:0] duty_wdata_i,
    input  logic             cmd_we_i,
    input  cmd_t             cmd_wdata_i,
    output logic [CNT_W-1:0] duty_pend_o,
    output cmd_t             cmd_pend_o,
    output logic             in1_o,
    output logic             in2_o
);

    localparam int unsigned DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);

    logic [CNT_W-1:0]  duty_pend_q, duty_act_q;
    cmd_t              cmd_pend_q, cmd_act_q;
    chan_state_e       state_q, state_d;
    cmd_t              mode_q, mode_d;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic              in1_q, in2_q;
    logic [1:0]        pins_d;
    cmd_t              eff_cmd_c;
    logic              pwm_c;

    // Pending/active shadow registers; a fault wipes both command copies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_pend_q <= '0;
            duty_act_q  <= '0;
            cmd_pend_q  <= CMD_COAST;
            cmd_act_q   <= CMD_COAST;
        end else begin
            if (duty_we_i) duty_pend_q <= duty_wdata_i;
            if (upd_i)     duty_act_q  <= duty_pend_q;
            if (fault_i) begin
                cmd_pend_q <= CMD_COAST;
                cmd_act_q  <= CMD_COAST;
            end else begin
                if (cmd_we_i && !cmd_lock_i) cmd_pend_q <= cmd_wdata_i;
                if (upd_i)                   cmd_act_q  <= cmd_pend_q;
            end
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_COAST;
            mode_q  <= CMD_COAST;
            dead_q  <= '0;
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dead_q  <= dead_d;
            in1_q   <= pins_d[1];
            in2_q   <= pins_d[0];
        end
    end

    // Next state; outputs follow the next state so COAST and dead-time take
    // effect on the same edge the FSM decides them.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        dead_d    = dead_q;
        eff_cmd_c = en_i ? cmd_act_q : CMD_COAST;
        pwm_c     = (cnt_i < duty_act_q);
        if (fault_i || eff_cmd_c == CMD_COAST) begin
            state_d = ST_COAST;
            mode_d  = CMD_COAST;
            dead_d  = '0;
        end else begin
            unique case (state_q)
                ST_COAST: begin
                    state_d = ST_DRIVE;
                    mode_d  = eff_cmd_c;
                end
                ST_DRIVE: begin
                    if (eff_cmd_c != mode_q) begin
                        state_d = ST_DEAD;
                        mode_d  = eff_cmd_c;
                        dead_d  = DEAD_LOAD;
                    end
                end
                ST_DEAD: begin
                    // Target may change while dead; the countdown keeps running.
                    mode_d = eff_cmd_c;
                    if (dead_q == '0) state_d = ST_DRIVE;
                    else              dead_d  = dead_q - DEAD_W'(1);
                end
                default: state_d = ST_COAST;
            endcase
        end
        pins_d = (state_d == ST_DRIVE) ? drive_pair(mode_d, pwm_c) : 2'b00;
    end

    assign duty_pend_o = duty_pend_q;
    assign cmd_pend_o  = cmd_pend_q;
    assign in1_o       = in1_q;
    assign in2_o       = in2_q;

endmodule

// File: rtl/labmininios_hbridge_pwm.sv
// Avalon-MM H-bridge PWM controller for N_CH channels with period-aligned
// shadow updates and dead-time on drive-mode changes.
// Optional fault input enabled by defining HBRIDGE_FAULT_EN.
//   clk, reset_n       clock, async active-low reset
//   avs                Avalon-MM slave bus (labmininios_hbridge_pwm_if.slave)
//   hb_in1, hb_in2     bridge inputs per channel
//   fault_n, irq       (HBRIDGE_FAULT_EN) driver fault in, sticky fault interrupt
module labmininios_hbridge_pwm
    import labmininios_hbridge_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DEAD_CYC = 8,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    labmininios_hbridge_pwm_if.slave  avs,
    output logic [N_CH-1:0]           hb_in1,
    output logic [N_CH-1:0]           hb_in2
`ifdef HBRIDGE_FAULT_EN
    ,
    input  logic                      fault_n,
    output logic                      irq
`endif
);

    logic             wr_c;
    logic             ctrl_en_q;
    logic [CNT_W-1:0] period_pend_q, period_act_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_c, upd_c;
    logic             fault_c, status_c;
    logic [31:0]      rdata_c;
    logic [CNT_W-1:0] duty_pend [N_CH];
    cmd_t             cmd_pend  [N_CH];
    logic             unused_wdata;

    assign wr_c         = avs.chipselect & ~avs.write_n;
    assign unused_wdata = ^avs.writedata;

    // Wrap on the last count, or every cycle for a degenerate period.
    assign wrap_c = ctrl_en_q &
                    ((period_act_q < CNT_W'(2)) || (cnt_q >= period_act_q - CNT_W'(1)));
    assign upd_c  = ~ctrl_en_q | wrap_c;
    assign cnt_d  = (!ctrl_en_q || wrap_c) ? '0 : cnt_q + CNT_W'(1);

    // CTRL, PERIOD shadow pair and shared counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en_q     <= 1'b0;
            period_pend_q <= '0;
            period_act_q  <= '0;
            cnt_q         <= '0;
        end else begin
            if (wr_c && avs.address == ADDR_W'(REG_CTRL))   ctrl_en_q     <= avs.writedata[0];
            if (wr_c && avs.address == ADDR_W'(REG_PERIOD)) period_pend_q <= avs.writedata[CNT_W-1:0];
            if (upd_c)                                      period_act_q  <= period_pend_q;
            cnt_q <= cnt_d;
        end
    end

`ifdef HBRIDGE_FAULT_EN
    logic [1:0] fault_sync_q;
    logic       status_q;

    // Two-flop synchroniser and sticky, write-1-to-clear fault status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_sync_q <= 2'b11;
            status_q     <= 1'b0;
        end else begin
            fault_sync_q <= {fault_sync_q[0], fault_n};
            if (fault_c)
                status_q <= 1'b1;
            else if (wr_c && avs.address == ADDR_W'(REG_STATUS) && avs.writedata[0])
                status_q <= 1'b0;
        end
    end

    assign fault_c  = ~fault_sync_q[1];
    assign status_c = status_q;
    assign irq      = status_q;
`else
    assign fault_c  = 1'b0;
    assign status_c = 1'b0;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        labmininios_hbridge_chan #(
            .CNT_W    (CNT_W),
            .DEAD_CYC (DEAD_CYC)
        ) u_chan (
            .clk          (clk),
            .reset_n      (reset_n),
            .en_i         (ctrl_en_q),
            .upd_i        (upd_c),
            .fault_i      (fault_c),
            .cmd_lock_i   (status_c),
            .cnt_i        (cnt_q),
            .duty_we_i    (wr_c && avs.address == ADDR_W'(REG_DUTY0 + 2 * k)),
            .duty_wdata_i (avs.writedata[CNT_W-1:0]),
            .cmd_we_i     (wr_c && avs.address == ADDR_W'(REG_CMD0 + 2 * k)),
            .cmd_wdata_i  (avs.writedata[1:0]),
            .duty_pend_o  (duty_pend[k]),
            .cmd_pend_o   (cmd_pend[k]),
            .in1_o        (hb_in1[k]),
            .in2_o        (hb_in2[k])
        );
    end

    // Zero-wait-state read mux; unmapped words read 0.
    always_comb begin
        rdata_c = '0;
        if (avs.address == ADDR_W'(REG_CTRL))   rdata_c = {31'b0, ctrl_en_q};
        if (avs.address == ADDR_W'(REG_PERIOD)) rdata_c = 32'(period_pend_q);
        if (avs.address == ADDR_W'(REG_STATUS)) rdata_c = {31'b0, status_c};
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (avs.address == ADDR_W'(REG_DUTY0 + 2 * k)) rdata_c = 32'(duty_pend[k]);
            if (avs.address == ADDR_W'(REG_CMD0 + 2 * k))  rdata_c = 32'(cmd_pend[k]);
        end
    end

    assign avs.readdata = rdata_c;

endmodule
